// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge memory bridge.
package cart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    localparam int unsigned DEF_AW    = 25;
    localparam logic [7:0]  IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/cart_mem_rcache.sv
// One-entry read cache: tag/valid/data with lookup, fill and invalidate.
module cart_mem_rcache
    import cart_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [AW-1:0] i_lookup_addr,
    output logic          o_hit,
    output logic [7:0]    o_data,
    input  logic          i_fill,
    input  logic [AW-1:0] i_fill_addr,
    input  logic [7:0]    i_fill_data,
    input  logic          i_inv,
    input  logic [AW-1:0] i_inv_addr,
    input  logic          i_inv_all
);

    logic          r_valid;
    logic [AW-1:0] r_tag;
    logic [7:0]    r_data;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= IDLE_BYTE;
        end else if (i_fill) begin
            r_valid <= CACHE_EN;
            r_tag   <= i_fill_addr;
            r_data  <= i_fill_data;
        end else if (i_inv_all || (i_inv && (r_tag == i_inv_addr))) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit  = CACHE_EN && r_valid && (r_tag == i_lookup_addr);
    assign o_data = r_data;

endmodule

// File: rtl/cart_mem_bridge.sv
// Bridges cart_rom's ram_* port to the req/ack cartridge memory controller,
// with a one-entry read cache and a one-deep write buffer.
module cart_mem_bridge
    import cart_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned TIMEOUT  = 255,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_rd,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic          mem_ack,
    input  logic [7:0]    mem_dout,
    output logic          timeout_err
);

    localparam int unsigned     CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        r_state, w_next_state;
    logic          r_mem_req, r_mem_we, r_timeout_err, r_wb_full;
    logic [AW-1:0] r_mem_addr, r_wb_addr;
    logic [7:0]    r_mem_din, r_cpu_dout, r_wb_din;
    logic [CW-1:0] r_cnt;

    logic          w_hit, w_tmo;
    logic [7:0]    w_cache_data;
    logic          w_issue_wr, w_issue_rd, w_wb_drain, w_wb_capture;
    logic          w_finish, w_abort, w_hit_load;
    logic [AW-1:0] w_wr_addr;
    logic [7:0]    w_wr_din;

    assign w_wr_addr = r_wb_full ? r_wb_addr : cpu_addr;
    assign w_wr_din  = r_wb_full ? r_wb_din  : cpu_din;
    assign w_tmo     = (TIMEOUT != 0) && (r_cnt == LAST);

    always_comb begin
        w_next_state = r_state;
        w_issue_wr   = 1'b0;
        w_issue_rd   = 1'b0;
        w_wb_drain   = 1'b0;
        w_wb_capture = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        w_hit_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_wb_full) begin
                    // a write arriving while the buffer drains takes its place
                    w_issue_wr   = 1'b1;
                    w_wb_drain   = 1'b1;
                    w_wb_capture = cpu_we;
                    w_next_state = WR_WAIT;
                end else if (cpu_we) begin
                    w_issue_wr   = 1'b1;
                    w_next_state = WR_WAIT;
                end else if (cpu_rd && !w_hit) begin
                    w_issue_rd   = 1'b1;
                    w_next_state = RD_WAIT;
                end else if (cpu_rd) begin
                    w_hit_load   = 1'b1;
                end
            end
            WR_WAIT, RD_WAIT: begin
                w_wb_capture = cpu_we;
                if (mem_ack) begin
                    w_finish     = 1'b1;
                    w_next_state = IDLE;
                end else if (w_tmo) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_cpu_dout    <= IDLE_BYTE;
            r_wb_full     <= 1'b0;
            r_wb_addr     <= '0;
            r_wb_din      <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_issue_wr) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b1;
                r_mem_addr <= w_wr_addr;
                r_mem_din  <= w_wr_din;
                r_cnt      <= '0;
            end else if (w_issue_rd) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= cpu_addr;
                r_cnt      <= '0;
            end else if (w_finish || w_abort) begin
                r_mem_req  <= 1'b0;
            end else if (r_state != IDLE) begin
                r_cnt      <= r_cnt + 1'b1;
            end

            if (w_finish && (r_state == RD_WAIT))
                r_cpu_dout <= mem_dout;
            else if (w_abort && (r_state == RD_WAIT))
                r_cpu_dout <= IDLE_BYTE;
            else if (w_hit_load)
                r_cpu_dout <= w_cache_data;

            if (w_abort)
                r_timeout_err <= 1'b1;

            if (w_wb_capture) begin
                r_wb_full <= 1'b1;
                r_wb_addr <= cpu_addr;
                r_wb_din  <= cpu_din;
            end else if (w_wb_drain) begin
                r_wb_full <= 1'b0;
            end
        end
    end

    // invalidation at issue also covers writes that later time out
    cart_mem_rcache #(
        .AW       (AW),
        .CACHE_EN (CACHE_EN)
    ) u_rcache (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_lookup_addr (cpu_addr),
        .o_hit         (w_hit),
        .o_data        (w_cache_data),
        .i_fill        (w_finish && (r_state == RD_WAIT)),
        .i_fill_addr   (r_mem_addr),
        .i_fill_data   (mem_dout),
        .i_inv         (w_issue_wr),
        .i_inv_addr    (w_wr_addr),
        .i_inv_all     (w_abort && (r_state == RD_WAIT))
    );

    assign cpu_ready   = reset_n && (r_state == IDLE) && !r_wb_full && !cpu_we
                         && (!cpu_rd || w_hit);
    assign cpu_dout    = r_cpu_dout;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_din     = r_mem_din;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cart_mem_bridge.sv
// Self-checking bench for cart_mem_bridge: vector table, corner sequences
// and randomized traffic against a CPU-level memory/cache model.
module tb_cart_mem_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [24:0] cpu_addr;
    logic        cpu_rd, cpu_we;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ready;
    logic        mem_req, mem_we;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_ack;
    logic [7:0]  mem_dout;
    logic        timeout_err;

    cart_mem_bridge #(.AW(25), .TIMEOUT(8), .CACHE_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd),
        .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_ack(mem_ack), .mem_dout(mem_dout), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [7:0]  din;
    } req_t;

    typedef struct {
        bit          wr;
        logic [24:0] addr;
        logic [7:0]  din;
        int unsigned lat;
        logic [7:0]  exp_dout;
        int unsigned exp_reqs;
    } vec_t;

    int unsigned total = 0;
    int unsigned bad   = 0;

    req_t        req_log[$];
    logic [7:0]  ctl_mem [logic [24:0]];
    logic [7:0]  ref_mem [logic [24:0]];
    int unsigned lat_cfg = 1;
    bit          no_ack  = 1'b0;
    bit          busy    = 1'b0;
    int unsigned remaining;
    req_t        cur;

    function automatic logic [7:0] def_byte(input logic [24:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ctl_rd(input logic [24:0] a);
        return ctl_mem.exists(a) ? ctl_mem[a] : def_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [24:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : def_byte(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory controller: acks the lat_cfg-th cycle of each request.
    initial begin
        mem_ack  = 1'b0;
        mem_dout = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_ack  = 1'b0;
            mem_dout = 8'($urandom);
            if (!busy && mem_req) begin
                busy      = 1'b1;
                remaining = no_ack ? 1000 : lat_cfg;
                cur       = '{we: mem_we, addr: mem_addr, din: mem_din};
                req_log.push_back(cur);
            end
            if (busy) begin
                remaining--;
                if (remaining == 0) begin
                    mem_ack = 1'b1;
                    busy    = 1'b0;
                    if (cur.we) ctl_mem[cur.addr] = cur.din;
                    else        mem_dout = ctl_rd(cur.addr);
                end else if (!mem_req && no_ack) begin
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cpu_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(name, ok, 1);
    endtask

    task automatic do_read(input logic [24:0] a, input int unsigned lat,
                           output logic [7:0] dout, output int unsigned reqs,
                           output logic rdy0);
        int unsigned n0;
        n0      = req_log.size();
        lat_cfg = lat;
        cpu_addr = a;
        cpu_rd   = 1'b1;
        #1 rdy0  = cpu_ready;
        step();
        wait_ready("rd_ready_bound");
        dout   = cpu_dout;
        reqs   = req_log.size() - n0;
        cpu_rd = 1'b0;
    endtask

    task automatic do_write(input logic [24:0] a, input logic [7:0] d,
                            input int unsigned lat, output int unsigned reqs);
        int unsigned n0;
        n0       = req_log.size();
        lat_cfg  = lat;
        cpu_addr = a;
        cpu_din  = d;
        cpu_we   = 1'b1;
        step();
        cpu_we   = 1'b0;
        wait_ready("wr_ready_bound");
        reqs = req_log.size() - n0;
        if (reqs != 0)
            chk("wr_entry", {req_log[n0].we, req_log[n0].addr, req_log[n0].din}, {1'b1, a, d});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cpu_rd  = 1'b0;
        cpu_we  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        vec_t        vecs[13];
        logic [7:0]  d, exp_d;
        int unsigned reqs, cnt, exp_reqs;
        logic        rdy0;
        logic [24:0] a, mc_addr;
        bit          mc_valid;

        vecs[0]  = '{1'b0, 25'h04000, 8'h00, 3, 8'h3C, 1};
        vecs[1]  = '{1'b0, 25'h04000, 8'h00, 1, 8'h3C, 0};
        vecs[2]  = '{1'b0, 25'h04001, 8'h00, 2, 8'h5B, 1};
        vecs[3]  = '{1'b0, 25'h04001, 8'h00, 1, 8'h5B, 0};
        vecs[4]  = '{1'b0, 25'h04000, 8'h00, 1, 8'h3C, 1};
        vecs[5]  = '{1'b1, 25'h04000, 8'h55, 2, 8'h00, 1};
        vecs[6]  = '{1'b0, 25'h04000, 8'h00, 2, 8'h55, 1};
        vecs[7]  = '{1'b0, 25'h04000, 8'h00, 1, 8'h55, 0};
        vecs[8]  = '{1'b1, 25'h04001, 8'h77, 1, 8'h00, 1};
        vecs[9]  = '{1'b0, 25'h04000, 8'h00, 1, 8'h55, 0};
        vecs[10] = '{1'b0, 25'h04001, 8'h00, 4, 8'h77, 1};
        vecs[11] = '{1'b0, 25'h04001, 8'h00, 1, 8'h77, 0};
        vecs[12] = '{1'b0, 25'h04002, 8'h00, 8, 8'h58, 1};

        ctl_mem[25'h04000] = 8'h3C;
        reset_n  = 1'b0;
        cpu_addr = '0;
        cpu_rd   = 1'b0;
        cpu_we   = 1'b0;
        cpu_din  = '0;
        step();
        step();
        chk("rst_ready", cpu_ready, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_dout", cpu_dout, 8'hFF);
        chk("rst_terr", timeout_err, 0);
        reset_n = 1'b1;
        #1 chk("post_rst_ready", cpu_ready, 1);
        step();

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].din, vecs[i].lat, reqs);
                chk($sformatf("v%0d_reqs", i), reqs, vecs[i].exp_reqs);
            end else begin
                do_read(vecs[i].addr, vecs[i].lat, d, reqs, rdy0);
                chk($sformatf("v%0d_reqs", i), reqs, vecs[i].exp_reqs);
                chk($sformatf("v%0d_dout", i), d, vecs[i].exp_dout);
                chk($sformatf("v%0d_ready0", i), rdy0, vecs[i].exp_reqs == 0);
            end
        end
        chk("ack_at_limit_terr", timeout_err, 0);

        // back-to-back write pulses; second lands in the write buffer
        cnt      = req_log.size();
        lat_cfg  = 2;
        cpu_we   = 1'b1;
        cpu_addr = 25'h00000;
        cpu_din  = 8'h10;
        step();
        cpu_addr = 25'h00001;
        cpu_din  = 8'h20;
        step();
        cpu_we   = 1'b0;
        wait_ready("b2b_ready_bound");
        chk("b2b_reqs", req_log.size() - cnt, 2);
        if (req_log.size() >= cnt + 2) begin
            chk("b2b_first",  {req_log[cnt].we, req_log[cnt].addr, req_log[cnt].din},
                {1'b1, 25'h00000, 8'h10});
            chk("b2b_second", {req_log[cnt+1].we, req_log[cnt+1].addr, req_log[cnt+1].din},
                {1'b1, 25'h00001, 8'h20});
        end
        chk("b2b_mem0", ctl_rd(25'h00000), 8'h10);
        chk("b2b_mem1", ctl_rd(25'h00001), 8'h20);

        // read that is never acknowledged
        no_ack   = 1'b1;
        cpu_addr = 25'h04003;
        cpu_rd   = 1'b1;
        step();
        cpu_rd   = 1'b0;
        cnt      = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            cnt++;
            step();
        end
        no_ack = 1'b0;
        chk("tmo_req_cycles", cnt, 8);
        chk("tmo_dout", cpu_dout, 8'hFF);
        chk("tmo_terr", timeout_err, 1);
        chk("tmo_ready", cpu_ready, 1);
        do_read(25'h04002, 2, d, reqs, rdy0);
        chk("tmo_inval_reqs", reqs, 1);
        chk("tmo_inval_dout", d, 8'h58);
        chk("tmo_sticky", timeout_err, 1);

        // reset during RD_WAIT with the ack arriving just after
        lat_cfg  = 2;
        cpu_addr = 25'h04000;
        cpu_rd   = 1'b1;
        step();
        chk("rstmid_req", mem_req, 1);
        reset_n  = 1'b0;
        cpu_rd   = 1'b0;
        step();
        reset_n  = 1'b1;
        step();
        chk("rstmid_req_after", mem_req, 0);
        chk("rstmid_dout", cpu_dout, 8'hFF);
        chk("rstmid_ready", cpu_ready, 1);
        chk("rstmid_terr", timeout_err, 0);
        do_read(25'h04002, 1, d, reqs, rdy0);
        chk("rstmid_inval_reqs", reqs, 1);
        chk("rstmid_inval_dout", d, 8'h58);

        // randomized traffic against a CPU-level memory and single-entry cache model
        do_reset();
        mc_valid = 1'b0;
        mc_addr  = '0;
        for (int k = 0; k < 150; k++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
            a = 25'h10000 + 25'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                d = 8'($urandom);
                do_write(a, d, $urandom_range(1, 8), reqs);
                chk($sformatf("rnd%0d_wr_reqs", k), reqs, 1);
                ref_mem[a] = d;
                if (mc_valid && mc_addr == a) mc_valid = 1'b0;
            end else begin
                exp_d    = ref_rd(a);
                exp_reqs = (mc_valid && mc_addr == a) ? 0 : 1;
                do_read(a, $urandom_range(1, 8), d, reqs, rdy0);
                chk($sformatf("rnd%0d_rd_dout", k), d, exp_d);
                chk($sformatf("rnd%0d_rd_reqs", k), reqs, exp_reqs);
                chk($sformatf("rnd%0d_rd_ready0", k), rdy0, exp_reqs == 0);
                mc_valid = 1'b1;
                mc_addr  = a;
            end
        end
        chk("rnd_terr", timeout_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
